// File: rtl/mem_arb.sv
// ----------------------------------------------------------------------------
// mem_arb : round-robin IFU/LSU arbiter onto a single-outstanding memory port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  input  logic [1:0]  lsu_size,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic [1:0]  mem_size,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);

  localparam int              CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]     TIMEOUT_DATA = 32'hdeadbeef;
  localparam logic            GRANT_IFU = 1'b0;
  localparam logic            GRANT_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       ifu_rdata_q, ifu_rdata_d;
  logic [31:0]       lsu_rdata_q, lsu_rdata_d;
  logic              timeout_err_q, timeout_err_d;
  logic              pick_lsu;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    mem_addr_d    = mem_addr_q;
    mem_wen_d     = mem_wen_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wmask_d   = mem_wmask_q;
    mem_size_d    = mem_size_q;
    cnt_d         = cnt_q;
    ifu_rdata_d   = ifu_rdata_q;
    lsu_rdata_d   = lsu_rdata_q;
    timeout_err_d = timeout_err_q;
    pick_lsu      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ifu_reqValid || lsu_reqValid) begin
          // On a tie the master that did not win last time gets the port.
          if (ifu_reqValid && lsu_reqValid) begin
            pick_lsu = (last_grant_q == GRANT_IFU);
          end else begin
            pick_lsu = lsu_reqValid;
          end
          grant_d      = pick_lsu ? GRANT_LSU : GRANT_IFU;
          last_grant_d = pick_lsu ? GRANT_LSU : GRANT_IFU;
          if (pick_lsu) begin
            mem_addr_d  = lsu_addr;
            mem_wen_d   = lsu_wen;
            mem_wdata_d = lsu_wdata;
            mem_wmask_d = lsu_wmask;
            mem_size_d  = lsu_size;
          end else begin
            mem_addr_d  = ifu_addr;
            mem_wen_d   = 1'b0;
            mem_wdata_d = 32'h0;
            mem_wmask_d = 4'h0;
            mem_size_d  = 2'b10;
          end
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_respValid) begin
          if (grant_q == GRANT_LSU) lsu_rdata_d = mem_rdata;
          else                      ifu_rdata_d = mem_rdata;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          if (grant_q == GRANT_LSU) lsu_rdata_d = TIMEOUT_DATA;
          else                      ifu_rdata_d = TIMEOUT_DATA;
          timeout_err_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= GRANT_IFU;
      last_grant_q  <= GRANT_LSU;
      mem_addr_q    <= 32'h0;
      mem_wen_q     <= 1'b0;
      mem_wdata_q   <= 32'h0;
      mem_wmask_q   <= 4'h0;
      mem_size_q    <= 2'b00;
      cnt_q         <= '0;
      ifu_rdata_q   <= 32'h0;
      lsu_rdata_q   <= 32'h0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      mem_addr_q    <= mem_addr_d;
      mem_wen_q     <= mem_wen_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wmask_q   <= mem_wmask_d;
      mem_size_q    <= mem_size_d;
      cnt_q         <= cnt_d;
      ifu_rdata_q   <= ifu_rdata_d;
      lsu_rdata_q   <= lsu_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_reqValid  = (state_q == ISSUE);
  assign ifu_respValid = (state_q == RESP) && (grant_q == GRANT_IFU);
  assign lsu_respValid = (state_q == RESP) && (grant_q == GRANT_LSU);
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign mem_size      = mem_size_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign timeout_err   = timeout_err_q;

endmodule

`default_nettype wire
